// File: rtl/mem_bus_arbiter.sv
// Two-to-one arbiter (data over inst) onto a single-outstanding memory port; 3-cycle minimum req-to-ready.
// Backpressure: requesters hold until ready, stall outputs cover the wait. Optional macro ARB_STARVE_GUARD_EN forces an inst grant after three contested data grants.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        grant_data, grant_inst;
    logic        inst_first;
    logic        done;

`ifdef ARB_STARVE_GUARD_EN
    logic [1:0] starve_q, starve_d;

    assign inst_first = inst_req && (starve_q == 2'd3);

    // Only contested data grants count; at 3 no further data grant can be contested, so no wrap.
    always_comb begin
        starve_d = starve_q;
        if (grant_inst) begin
            starve_d = 2'd0;
        end else if (grant_data && inst_req) begin
            starve_d = starve_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign inst_first = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        grant_data = 1'b0;
        grant_inst = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req && !inst_first) begin
                    grant_data = 1'b1;
                    owner_d    = OWN_DATA;
                    wr_d       = data_wr;
                    addr_d     = data_addr;
                    wdata_d    = data_wdata;
                    wstrb_d    = data_wstrb;
                    state_d    = S_ADDR;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                    owner_d    = OWN_INST;
                    wr_d       = 1'b0;
                    addr_d     = inst_addr;
                    wdata_d    = 32'd0;
                    wstrb_d    = 4'b0000;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= OWN_INST;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign bus_req   = (state_q == S_ADDR);
    assign bus_wr    = wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;

    // data_ok seen in ADDR is deliberately dropped: only WAIT completes a transaction.
    assign done       = (state_q == S_WAIT) && bus_data_ok;
    assign inst_ready = done && (owner_q == OWN_INST);
    assign data_ready = done && (owner_q == OWN_DATA);
    assign inst_rdata = inst_ready ? bus_rdata : 32'd0;
    assign data_rdata = data_ready ? bus_rdata : 32'd0;

    assign stallreq_if  = inst_req & ~inst_ready;
    assign stallreq_mem = data_req & ~data_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; inputs change on the falling edge, outputs checked 1ns later.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_ready;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic [3:0]  data_wstrb = 4'd0;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        stallreq_if;
    logic        stallreq_mem;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [31:0] exp_addr;
    logic        exp_inst;

    initial begin
        // Reset state
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_inst_ready", 32'(inst_ready), 32'd0);
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        cyc(); resetn = 1'b1;

        // Single fetch, minimum latency
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00000; #1;
        chk("f_c1_bus_req", 32'(bus_req), 32'd0);
        chk("f_c1_stall_if", 32'(stallreq_if), 32'd1);
        cyc(); bus_addr_ok = 1'b1; #1;
        chk("f_c2_bus_req", 32'(bus_req), 32'd1);
        chk("f_c2_bus_addr", bus_addr, 32'hBFC00000);
        chk("f_c2_bus_wr", 32'(bus_wr), 32'd0);
        chk("f_c2_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("f_c2_inst_ready", 32'(inst_ready), 32'd0);
        chk("f_c2_stall_if", 32'(stallreq_if), 32'd1);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C1A0000; #1;
        chk("f_c3_bus_req", 32'(bus_req), 32'd0);
        chk("f_c3_inst_ready", 32'(inst_ready), 32'd1);
        chk("f_c3_inst_rdata", inst_rdata, 32'h3C1A0000);
        chk("f_c3_stall_if", 32'(stallreq_if), 32'd0);
        chk("f_c3_data_ready", 32'(data_ready), 32'd0);
        chk("f_c3_data_rdata", data_rdata, 32'd0);
        cyc(); inst_req = 1'b0; bus_data_ok = 1'b0; #1;
        chk("f_c4_inst_ready", 32'(inst_ready), 32'd0);
        chk("f_c4_inst_rdata", inst_rdata, 32'd0);
        cyc(); #1;
        chk("f_idle_bus_req", 32'(bus_req), 32'd0);

        // Simultaneous store and fetch: store first
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80001000;
        data_wdata = 32'hDEADBEEF; data_wstrb = 4'b1111; #1;
        chk("sf_g_bus_req", 32'(bus_req), 32'd0);
        cyc(); bus_addr_ok = 1'b1; #1;
        chk("sf_st_bus_req", 32'(bus_req), 32'd1);
        chk("sf_st_bus_wr", 32'(bus_wr), 32'd1);
        chk("sf_st_bus_addr", bus_addr, 32'h80001000);
        chk("sf_st_bus_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sf_st_bus_wstrb", 32'(bus_wstrb), 32'hF);
        chk("sf_st_stall_if", 32'(stallreq_if), 32'd1);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678; #1;
        chk("sf_st_data_ready", 32'(data_ready), 32'd1);
        chk("sf_st_inst_ready", 32'(inst_ready), 32'd0);
        chk("sf_st_inst_rdata", inst_rdata, 32'd0);
        chk("sf_st_stall_mem", 32'(stallreq_mem), 32'd0);
        chk("sf_st_stall_if", 32'(stallreq_if), 32'd1);
        cyc(); data_req = 1'b0; data_wr = 1'b0; bus_data_ok = 1'b0; #1;
        chk("sf_gap_bus_req", 32'(bus_req), 32'd0);
        chk("sf_gap_stall_if", 32'(stallreq_if), 32'd1);
        cyc(); bus_addr_ok = 1'b1; #1;
        chk("sf_ld_bus_req", 32'(bus_req), 32'd1);
        chk("sf_ld_bus_addr", bus_addr, 32'hBFC00004);
        chk("sf_ld_bus_wr", 32'(bus_wr), 32'd0);
        chk("sf_ld_bus_wstrb", 32'(bus_wstrb), 32'd0);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA5555; #1;
        chk("sf_ld_inst_ready", 32'(inst_ready), 32'd1);
        chk("sf_ld_inst_rdata", inst_rdata, 32'hAAAA5555);
        cyc(); inst_req = 1'b0; bus_data_ok = 1'b0;

        // addr_ok withheld for 5 cycles
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00008;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80002000; #1;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            chk("hold_bus_req", 32'(bus_req), 32'd1);
            chk("hold_bus_addr", bus_addr, 32'h80002000);
            chk("hold_data_ready", 32'(data_ready), 32'd0);
            chk("hold_stall_mem", 32'(stallreq_mem), 32'd1);
            chk("hold_stall_if", 32'(stallreq_if), 32'd1);
        end
        cyc(); bus_addr_ok = 1'b1; #1;
        chk("hold_ok_bus_req", 32'(bus_req), 32'd1);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D; #1;
        chk("hold_data_ready", 32'(data_ready), 32'd1);
        chk("hold_data_rdata", data_rdata, 32'h0BADF00D);
        cyc(); inst_req = 1'b0; data_req = 1'b0; bus_data_ok = 1'b0;

        // data_ok alongside addr_ok in ADDR is ignored
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00010;
        cyc(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h11111111; #1;
        chk("early_inst_ready", 32'(inst_ready), 32'd0);
        chk("early_inst_rdata", inst_rdata, 32'd0);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
        chk("early_wait_ready", 32'(inst_ready), 32'd0);
        chk("early_wait_bus_req", 32'(bus_req), 32'd0);
        cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h22222222; #1;
        chk("late_inst_ready", 32'(inst_ready), 32'd1);
        chk("late_inst_rdata", inst_rdata, 32'h22222222);
        cyc(); inst_req = 1'b0; bus_data_ok = 1'b0;

        // Request dropped during ADDR still completes
        cyc(); data_req = 1'b1; data_addr = 32'h80004000;
        cyc(); data_req = 1'b0; bus_addr_ok = 1'b1; #1;
        chk("drop_bus_req", 32'(bus_req), 32'd1);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55AA55AA; #1;
        chk("drop_data_ready", 32'(data_ready), 32'd1);
        chk("drop_data_rdata", data_rdata, 32'h55AA55AA);
        cyc(); bus_data_ok = 1'b0;

        // Reset during WAIT abandons the transaction
        cyc(); data_req = 1'b1; data_addr = 32'h80005000;
        cyc(); bus_addr_ok = 1'b1;
        cyc(); bus_addr_ok = 1'b0; resetn = 1'b0; #1;
        chk("rstw_bus_req", 32'(bus_req), 32'd0);
        chk("rstw_bus_addr", bus_addr, 32'd0);
        chk("rstw_data_ready", 32'(data_ready), 32'd0);
        cyc(); resetn = 1'b1; data_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h99999999; #1;
        chk("rstw_after_data_ready", 32'(data_ready), 32'd0);
        chk("rstw_after_data_rdata", data_rdata, 32'd0);
        chk("rstw_after_inst_ready", 32'(inst_ready), 32'd0);
        cyc(); bus_data_ok = 1'b0; #1;
        chk("rstw_idle_bus_req", 32'(bus_req), 32'd0);

        // Continuous contention: grant order
        cyc(); resetn = 1'b0;
        cyc(); resetn = 1'b1;
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80003000;
        for (int g = 0; g < 5; g++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_inst = (g == 3);
`else
            exp_inst = 1'b0;
`endif
            exp_addr = exp_inst ? 32'hBFC00100 : 32'h80003000;
            cyc(); bus_addr_ok = 1'b1; #1;
            chk($sformatf("order_addr_g%0d", g), bus_addr, exp_addr);
            cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'(g); #1;
            chk($sformatf("order_inst_ready_g%0d", g), 32'(inst_ready), 32'(exp_inst));
            chk($sformatf("order_data_ready_g%0d", g), 32'(data_ready), 32'(!exp_inst));
            cyc(); bus_data_ok = 1'b0;
        end
        inst_req = 1'b0; data_req = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
